key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CNT_MAX, default 500000, is the number of consecutive stable synchronized samples required to accept a key level change.
REQ-002 Parameter HOLD_DELAY_CNT, default 25000000, is the number of clk cycles from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_CNT, default 5000000, is the number of clk cycles between successive auto-repeat pulses.
REQ-004 Parameter KEY_ACTIVE_LOW, default 1: 1 means a raw key reads 0 when pressed, 0 means it reads 1 when pressed.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 key_inc_raw  input  1  asynchronous raw increment pushbutton.
REQ-008 key_dec_raw  input  1  asynchronous raw decrement pushbutton.
REQ-009 inc_pulse  output  1  single-cycle increment request that feeds the controller key_inc input.
REQ-010 dec_pulse  output  1  single-cycle decrement request that feeds the controller key_dec input.
REQ-011 inc_held  output  1  debounced increment level, active-high.
REQ-012 dec_held  output  1  debounced decrement level, active-high.
REQ-013 repeat_active  output  1  high while either key is in the REPEAT state.

Function
REQ-014 Each raw key SHALL pass through a 2-flop synchronizer and then be normalized to active-high according to KEY_ACTIVE_LOW.
REQ-015 Debounce counting, per key:
- A counter increments on each cycle where the synchronized level differs from the held level.
- The counter clears on any cycle where the two levels agree.
- The held level toggles, and the counter clears, on the edge where the count reaches DEBOUNCE_CNT_MAX.
REQ-016 Debounce counter width SHALL be $clog2(DEBOUNCE_CNT_MAX+1); the hold/repeat timer width SHALL be $clog2(max(HOLD_DELAY_CNT,REPEAT_CNT)+1); neither counter wraps.
REQ-017 Each key SHALL have an FSM with the states IDLE, HOLD, REPEAT and a shared timer per key.
- IDLE->HOLD on the rising edge of the held level: one pulse, timer cleared.
- HOLD->REPEAT when the timer reaches HOLD_DELAY_CNT-1 while still held: one pulse, timer cleared.
- REPEAT: one pulse each time the timer reaches REPEAT_CNT-1, then the timer clears.
- Any state->IDLE on release: timer cleared, no pulse.
REQ-018 Pulses SHALL be registered and exactly one cycle wide; press-to-first-pulse latency is DEBOUNCE_CNT_MAX+2 clk edges counted from the first edge that samples the pressed raw level.
REQ-019 Lockout:
- Both held levels high in the same cycle sets lockout, forces both FSMs to IDLE, and suppresses all pulses, including when both rising edges occur in the same cycle.
- Lockout clears only when both held levels are low.
- A key still held after the other is released SHALL NOT pulse until it is released and pressed again.
REQ-020 inc_pulse and dec_pulse SHALL never be high in the same cycle.
REQ-021 Glitches shorter than DEBOUNCE_CNT_MAX cycles after synchronization SHALL produce no change in the held level and no pulse.

Reset
REQ-022 While reset_n is low at a clk edge, the following SHALL clear, and keys are treated as released:
- synchronizers, set to the released level;
- debounce counters and timers, to 0;
- held levels, to 0;
- FSMs, to IDLE;
- lockout, to 0;
- all outputs, to 0.
REQ-023 A key held through the release of reset SHALL produce its first pulse DEBOUNCE_CNT_MAX+2 edges after the first edge with reset_n high.
REQ-024 Reset asserted mid-hold or mid-repeat SHALL drop outputs at that edge; no pulse is emitted in the reset cycle.

Verification
REQ-025 The bench SHALL use DEBOUNCE_CNT_MAX=4, HOLD_DELAY_CNT=20, REPEAT_CNT=5, KEY_ACTIVE_LOW=1.
REQ-026 Scenario, single press: key_inc_raw low for 10 cycles, then high -> exactly one inc_pulse, 6 edges after the press is sampled; inc_held high for the press duration; dec_pulse stays 0.
REQ-027 Scenario, bounce: key_dec_raw toggles low/high with 2-cycle periods for 12 cycles, then returns high -> dec_held stays 0 and no dec_pulse occurs.
REQ-028 Scenario, hold: key_inc_raw low for 60 cycles -> pulses at relative cycles 0, 20, 25, 30, 35, ...; repeat_active rises with the pulse at cycle 20; no pulse after release.
REQ-029 Scenario, conflict: press inc, then press dec 10 cycles later while inc is held -> no further pulses; release dec with inc still held -> no pulses; release and re-press inc -> one inc_pulse.
REQ-030 Scenario, reset mid-repeat: assert reset_n=0 for 2 cycles during REPEAT while the key is held -> all outputs 0 at the reset edge; the first pulse comes 6 edges after reset_n returns high.

Source files
------------

// File: rtl/key_conditioner.sv
// Pushbutton front end: synchronizes and debounces two keys, then turns each
// press into a single pulse followed by auto-repeat pulses while held.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CNT_MAX = 500000,
    parameter int unsigned HOLD_DELAY_CNT   = 25000000,
    parameter int unsigned REPEAT_CNT       = 5000000,
    parameter bit          KEY_ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_inc_raw,
    input  logic key_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held,
    output logic repeat_active
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CNT_MAX + 1);
    localparam int unsigned TMAX = (HOLD_DELAY_CNT > REPEAT_CNT) ? HOLD_DELAY_CNT : REPEAT_CNT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic        RELEASED = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Index 0 is the increment key, index 1 the decrement key.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    key_lvl;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    logic [1:0]    held_q, held_d;
    state_t        state_q [2];
    state_t        state_d [2];
    logic [TW-1:0] tmr_q [2];
    logic [TW-1:0] tmr_d [2];
    logic          lock_q, lock_d;
    logic [1:0]    pulse_q, pulse_d;
    logic          rep_q, rep_d;

    assign raw     = {key_dec_raw, key_inc_raw};
    assign key_lvl = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce: held level flips once the synchronized level disagrees long enough.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            held_d[k]   = held_q[k];
            if (key_lvl[k] != held_q[k]) begin
                if (db_cnt_q[k] == DW'(DEBOUNCE_CNT_MAX - 1)) begin
                    held_d[k] = ~held_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    // Lockout and per-key press/hold/repeat sequencing, driven by the new held levels
    // so the first pulse lands on the same edge the held level rises.
    always_comb begin
        lock_d = lock_q;
        if (&held_d) begin
            lock_d = 1'b1;
        end else if (~|held_d) begin
            lock_d = 1'b0;
        end

        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            tmr_d[k]   = tmr_q[k];
            pulse_d[k] = 1'b0;
            if (lock_d) begin
                state_d[k] = IDLE;
                tmr_d[k]   = '0;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        tmr_d[k] = '0;
                        if (held_d[k] && !held_q[k]) begin
                            state_d[k] = HOLD;
                            pulse_d[k] = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!held_d[k]) begin
                            state_d[k] = IDLE;
                            tmr_d[k]   = '0;
                        end else if (tmr_q[k] == TW'(HOLD_DELAY_CNT - 1)) begin
                            state_d[k] = REPEAT;
                            tmr_d[k]   = '0;
                            pulse_d[k] = 1'b1;
                        end else begin
                            tmr_d[k] = tmr_q[k] + TW'(1);
                        end
                    end
                    REPEAT: begin
                        if (!held_d[k]) begin
                            state_d[k] = IDLE;
                            tmr_d[k]   = '0;
                        end else if (tmr_q[k] == TW'(REPEAT_CNT - 1)) begin
                            tmr_d[k]   = '0;
                            pulse_d[k] = 1'b1;
                        end else begin
                            tmr_d[k] = tmr_q[k] + TW'(1);
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        tmr_d[k]   = '0;
                    end
                endcase
            end
        end

        rep_d = (state_d[0] == REPEAT) || (state_d[1] == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= {2{RELEASED}};
            sync2_q <= {2{RELEASED}};
            held_q  <= '0;
            lock_q  <= 1'b0;
            pulse_q <= '0;
            rep_q   <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
                tmr_q[k]    <= '0;
                state_q[k]  <= IDLE;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            lock_q  <= lock_d;
            pulse_q <= pulse_d;
            rep_q   <= rep_d;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
                tmr_q[k]    <= tmr_d[k];
                state_q[k]  <= state_d[k];
            end
        end
    end

    assign inc_pulse     = pulse_q[0];
    assign dec_pulse     = pulse_q[1];
    assign inc_held      = held_q[0];
    assign dec_held      = held_q[1];
    assign repeat_active = rep_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// checked cycle by cycle against a press-age reference model.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int HD = 20;
    localparam int RP = 5;

    logic clk         = 1'b0;
    logic reset_n     = 1'b0;
    logic key_inc_raw = 1'b1;
    logic key_dec_raw = 1'b1;
    logic inc_pulse, dec_pulse, inc_held, dec_held, repeat_active;

    key_conditioner #(
        .DEBOUNCE_CNT_MAX(DB),
        .HOLD_DELAY_CNT  (HD),
        .REPEAT_CNT      (RP),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_inc_raw  (key_inc_raw),
        .key_dec_raw  (key_dec_raw),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .inc_held     (inc_held),
        .dec_held     (dec_held),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: raw -> two-sample delay -> run-length debounce, then each
    // key's pulses follow from the age of the current press.
    logic [1:0] m_h0 = 2'b11, m_h1 = 2'b11;
    logic [1:0] m_lvl = 2'b00, m_held = 2'b00, m_prev = 2'b00;
    int         m_run [2] = '{0, 0};
    int         m_age [2] = '{0, 0};
    bit         m_active [2] = '{1'b0, 1'b0};
    logic       m_lock = 1'b0;
    logic [1:0] m_pulse = 2'b00;
    logic       m_rep = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_h0 = 2'b11; m_h1 = 2'b11; m_held = 2'b00; m_lock = 1'b0;
            m_pulse = 2'b00; m_rep = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_age[k] = 0; m_active[k] = 1'b0;
            end
        end else begin
            m_lvl  = ~m_h1;
            m_h1   = m_h0;
            m_h0   = {key_dec_raw, key_inc_raw};
            m_prev = m_held;
            for (int k = 0; k < 2; k++) begin
                if (m_lvl[k] != m_held[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_held[k] = ~m_held[k];
                        m_run[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            if (m_held == 2'b11) m_lock = 1'b1;
            else if (m_held == 2'b00) m_lock = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_pulse[k] = 1'b0;
                if (m_lock || !m_held[k]) begin
                    m_active[k] = 1'b0;
                end else if (!m_prev[k]) begin
                    m_active[k] = 1'b1;
                    m_age[k]    = 0;
                    m_pulse[k]  = 1'b1;
                end else if (m_active[k]) begin
                    m_age[k]++;
                    m_pulse[k] = (m_age[k] >= HD) && (((m_age[k] - HD) % RP) == 0);
                end
            end
            m_rep = (m_active[0] && m_age[0] >= HD) || (m_active[1] && m_age[1] >= HD);
        end
    end

    // Per-cycle comparison and event statistics for the directed scenarios.
    bit chk_en = 1'b0;
    int inc_cnt, dec_cnt, inc_first, inc_last, inc_held_cnt, dec_held_cnt, rep_first;

    task automatic clear_mon();
        inc_cnt = 0; dec_cnt = 0; inc_first = -1; inc_last = -1;
        inc_held_cnt = 0; dec_held_cnt = 0; rep_first = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("inc_pulse", int'(inc_pulse), int'(m_pulse[0]));
            check_val("dec_pulse", int'(dec_pulse), int'(m_pulse[1]));
            check_val("inc_held", int'(inc_held), int'(m_held[0]));
            check_val("dec_held", int'(dec_held), int'(m_held[1]));
            check_val("repeat_active", int'(repeat_active), int'(m_rep));
            check_val("pulse_excl", int'(inc_pulse & dec_pulse), 0);
            if (inc_pulse) begin
                inc_cnt++;
                if (inc_first < 0) inc_first = cyc;
                inc_last = cyc;
            end
            if (dec_pulse) dec_cnt++;
            if (inc_held) inc_held_cnt++;
            if (dec_held) dec_held_cnt++;
            if (repeat_active && rep_first < 0) rep_first = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int t0, t1;

    initial begin
        clear_mon();
        tick(3);
        chk_en = 1'b1;
        check_val("rst_inc_pulse", int'(inc_pulse), 0);
        check_val("rst_dec_pulse", int'(dec_pulse), 0);
        check_val("rst_inc_held", int'(inc_held), 0);
        check_val("rst_dec_held", int'(dec_held), 0);
        check_val("rst_repeat", int'(repeat_active), 0);
        reset_n = 1'b1;
        tick(5);

        // single press
        clear_mon();
        t0 = cyc;
        key_inc_raw = 1'b0;
        tick(10);
        key_inc_raw = 1'b1;
        tick(15);
        check_val("single_cnt", inc_cnt, 1);
        check_val("single_latency", inc_first - t0, DB + 2);
        check_val("single_held_len", inc_held_cnt, 10);
        check_val("single_dec", dec_cnt, 0);

        // bounce
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            key_dec_raw = 1'b0; tick(1);
            key_dec_raw = 1'b1; tick(1);
        end
        tick(15);
        check_val("bounce_held", dec_held_cnt, 0);
        check_val("bounce_pulse", dec_cnt, 0);

        // hold with auto-repeat
        clear_mon();
        t0 = cyc;
        key_inc_raw = 1'b0;
        tick(60);
        key_inc_raw = 1'b1;
        tick(20);
        check_val("hold_cnt", inc_cnt, 9);
        check_val("hold_first", inc_first - t0, DB + 2);
        check_val("hold_rep_rise", rep_first - t0, DB + 2 + HD);
        check_val("hold_last", inc_last - t0, DB + 2 + HD + 7 * RP);

        // conflict lockout
        key_inc_raw = 1'b0;
        tick(10);
        clear_mon();
        key_dec_raw = 1'b0;
        tick(30);
        key_dec_raw = 1'b1;
        tick(30);
        check_val("lock_inc", inc_cnt, 0);
        check_val("lock_dec", dec_cnt, 0);
        key_inc_raw = 1'b1;
        tick(15);
        clear_mon();
        key_inc_raw = 1'b0;
        tick(10);
        key_inc_raw = 1'b1;
        tick(15);
        check_val("relock_inc", inc_cnt, 1);
        check_val("relock_dec", dec_cnt, 0);

        // reset in the middle of repeat
        key_inc_raw = 1'b0;
        tick(35);
        check_val("pre_rst_repeat", int'(repeat_active), 1);
        reset_n = 1'b0;
        tick(1);
        check_val("rst_mid_pulse", int'(inc_pulse), 0);
        check_val("rst_mid_held", int'(inc_held), 0);
        check_val("rst_mid_repeat", int'(repeat_active), 0);
        tick(1);
        reset_n = 1'b1;
        t1 = cyc;
        clear_mon();
        tick(20);
        check_val("rst_mid_latency", inc_first - t1, DB + 2);
        key_inc_raw = 1'b1;
        tick(15);

        // random key activity with occasional resets
        for (int i = 0; i < 30; i++) begin
            key_inc_raw = 1'($urandom_range(0, 1));
            key_dec_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 12) == 0) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            tick($urandom_range(1, 45));
        end
        key_inc_raw = 1'b1;
        key_dec_raw = 1'b1;
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
